// File: rtl/luna_ctrl_pkg.sv
// rtl/luna_ctrl_pkg.sv - shared sequencer state type, legacy phase indices and dwell field helper
package luna_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_t;

    // Phase numbering inherited from the fixed four-phase controller
    localparam int PH_FETCH  = 0;
    localparam int PH_DECODE = 1;
    localparam int PH_EXEC   = 2;
    localparam int PH_WRBK   = 3;

    // Bit offset of dwell field idx inside the packed per-phase dwell vector
    function automatic int dwell_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/phase_sequencer_if.sv
// rtl/phase_sequencer_if.sv - control/status bundle between the core and the phase sequencer
interface phase_sequencer_if #(
    parameter int NUM_PHASES = 4,
    parameter int DWELL_W    = 4,
    parameter int CNT_W      = 16
);
    localparam int IDX_W = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;

    logic                          en;
    logic                          step_mode;
    logic                          step_req;
    logic                          stall;
    logic [NUM_PHASES*DWELL_W-1:0] dwell_cfg;
    logic [NUM_PHASES-1:0]         phase_en;
    logic [IDX_W-1:0]              phase_idx;
    logic                          busy;
    logic                          cycle_done;
    logic [CNT_W-1:0]              cycle_count;

    // Core side: issues run/step/stall requests and consumes the stage enables
    modport master (
        output en, step_mode, step_req, stall, dwell_cfg,
        input  phase_en, phase_idx, busy, cycle_done, cycle_count
    );

    // Sequencer side
    modport slave (
        input  en, step_mode, step_req, stall, dwell_cfg,
        output phase_en, phase_idx, busy, cycle_done, cycle_count
    );

endinterface

// File: rtl/phase_sequencer_dwell_counter.sv
// rtl/phase_sequencer_dwell_counter.sv - per-phase dwell down-counter with load/decrement/hold
module phase_dwell_counter #(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_load,
    input  logic               i_dec,
    input  logic [DWELL_W-1:0] i_load_val,
    output logic               o_zero
);

    logic [DWELL_W-1:0] r_count;

    // Load has priority so a phase entry always starts from its fresh dwell value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec) begin
            r_count <= r_count - DWELL_W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/phase_sequencer.sv
// rtl/phase_sequencer.sv - one-hot multi-phase enable sequencer with dwell, stall, stop and single-step
import luna_ctrl_pkg::*;

module phase_sequencer #(
    parameter int NUM_PHASES = 4,
    parameter int DWELL_W    = 4,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    phase_sequencer_if.slave   bus
);

    localparam int IDX_W = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_PHASES - 1);
    localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(PH_FETCH);

    seq_state_t            r_state;
    logic [IDX_W-1:0]      r_phase_idx;
    logic [NUM_PHASES-1:0] r_phase_en;
    logic                  r_cycle_done;
    logic [CNT_W-1:0]      r_cycle_count;
    logic                  r_step_q;

    logic                  w_step_rise;
    logic                  w_start;
    logic                  w_dwell_zero;
    logic                  w_last;
    logic                  w_run_go;
    logic                  w_advance;
    logic                  w_continue;
    logic                  w_load;
    logic                  w_dec;
    logic [IDX_W-1:0]      w_load_idx;
    logic [DWELL_W-1:0]    w_load_val;

    assign w_step_rise = bus.step_req & ~r_step_q;
    assign w_start     = (r_state == IDLE) & bus.en & (~bus.step_mode | w_step_rise);
    assign w_last      = (r_phase_idx == LAST_IDX);
    assign w_run_go    = (r_state == RUN) & ~bus.stall;
    assign w_advance   = w_run_go & w_dwell_zero & ~w_last;
    assign w_continue  = w_run_go & w_dwell_zero & w_last & bus.en & ~bus.step_mode;
    assign w_load      = w_start | w_advance | w_continue;
    assign w_dec       = w_run_go & ~w_dwell_zero;

    // Index of the phase being entered; dwell is sampled only at that moment
    always_comb begin
        w_load_idx = FIRST_IDX;
        if (w_advance) begin
            w_load_idx = r_phase_idx + IDX_W'(1);
        end
        w_load_val = bus.dwell_cfg[dwell_lsb(int'(w_load_idx), DWELL_W) +: DWELL_W];
    end

    phase_dwell_counter #(
        .DWELL_W (DWELL_W)
    ) u_dwell (
        .clk        (clk),
        .rst_n      (rst),
        .i_load     (w_load),
        .i_dec      (w_dec),
        .i_load_val (w_load_val),
        .o_zero     (w_dwell_zero)
    );

    // Sequencer FSM: start, phase rotation, cycle completion and stop decisions
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_phase_idx   <= '0;
            r_phase_en    <= '0;
            r_cycle_done  <= 1'b0;
            r_cycle_count <= '0;
            r_step_q      <= 1'b0;
        end else begin
            r_step_q     <= bus.step_req;
            r_cycle_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state     <= RUN;
                        r_phase_idx <= FIRST_IDX;
                        r_phase_en  <= NUM_PHASES'(1);
                    end
                end
                RUN: begin
                    if (w_run_go && w_dwell_zero) begin
                        if (!w_last) begin
                            r_phase_idx <= w_load_idx;
                            r_phase_en  <= r_phase_en << 1;
                        end else begin
                            // Cycle boundary: en and step_mode are only looked at here
                            r_cycle_done  <= 1'b1;
                            r_cycle_count <= r_cycle_count + CNT_W'(1);
                            r_phase_idx   <= FIRST_IDX;
                            if (bus.en && !bus.step_mode) begin
                                r_phase_en <= NUM_PHASES'(1);
                            end else begin
                                r_state    <= IDLE;
                                r_phase_en <= '0;
                            end
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.phase_en    = r_phase_en;
    assign bus.phase_idx   = r_phase_idx;
    assign bus.busy        = (r_state == RUN);
    assign bus.cycle_done  = r_cycle_done;
    assign bus.cycle_count = r_cycle_count;

endmodule

// File: tb/tb_phase_sequencer.sv
// tb/tb_phase_sequencer.sv - self-checking bench for phase_sequencer
module tb_phase_sequencer;

    logic clk;
    logic rst;

    phase_sequencer_if #(.NUM_PHASES(4), .DWELL_W(4), .CNT_W(16)) bus ();

    phase_sequencer #(.NUM_PHASES(4), .DWELL_W(4), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: an instruction cycle is a queue of phase slots, one per clock
    int sched[$];
    bit m_active;
    int m_cur;
    bit m_done;
    int m_count;
    bit m_prev_step;

    typedef struct {
        logic        st;
        logic [3:0]  pe;
        logic        done;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        sched.delete();
        m_active    = 0;
        m_cur       = 0;
        m_done      = 0;
        m_count     = 0;
        m_prev_step = 0;
    endtask

    task automatic m_load_cycle();
        sched.delete();
        for (int i = 0; i < 4; i++) begin
            int d;
            d = int'(bus.dwell_cfg[i*4 +: 4]);
            for (int k = 0; k <= d; k++) sched.push_back(i);
        end
        m_cur    = sched.pop_front();
        m_active = 1;
    endtask

    task automatic m_step();
        bit rise;
        if (!rst) begin
            m_reset();
            return;
        end
        m_done      = 0;
        rise        = bus.step_req && !m_prev_step;
        m_prev_step = bus.step_req;
        if (!m_active) begin
            if (bus.en && (!bus.step_mode || rise)) m_load_cycle();
        end else if (!bus.stall) begin
            if (sched.size() > 0) begin
                m_cur = sched.pop_front();
            end else begin
                m_done  = 1;
                m_count = (m_count + 1) & 16'hFFFF;
                if (bus.en && !bus.step_mode) m_load_cycle();
                else m_active = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        m_step();
        #1;
        chk("model_phase_en",  32'(bus.phase_en),    m_active ? (32'd1 << m_cur) : 32'd0);
        chk("model_phase_idx", 32'(bus.phase_idx),   m_active ? 32'(m_cur) : 32'd0);
        chk("model_busy",      32'(bus.busy),        32'(m_active));
        chk("model_done",      32'(bus.cycle_done),  32'(m_done));
        chk("model_count",     32'(bus.cycle_count), 32'(m_count));
    endtask

    task automatic do_reset(input logic [15:0] cfg, input logic e, input logic sm);
        rst           = 1'b0;
        bus.en        = e;
        bus.step_mode = sm;
        bus.step_req  = 1'b0;
        bus.stall     = 1'b0;
        bus.dwell_cfg = cfg;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        int dones;
        logic [15:0] cfg;

        vecs[0]  = '{1'b0, 4'b0001, 1'b0, 16'd0};
        vecs[1]  = '{1'b0, 4'b0010, 1'b0, 16'd0};
        vecs[2]  = '{1'b0, 4'b0100, 1'b0, 16'd0};
        vecs[3]  = '{1'b0, 4'b1000, 1'b0, 16'd0};
        vecs[4]  = '{1'b0, 4'b0001, 1'b1, 16'd1};
        vecs[5]  = '{1'b0, 4'b0010, 1'b0, 16'd1};
        vecs[6]  = '{1'b0, 4'b0100, 1'b0, 16'd1};
        vecs[7]  = '{1'b1, 4'b0100, 1'b0, 16'd1};
        vecs[8]  = '{1'b1, 4'b0100, 1'b0, 16'd1};
        vecs[9]  = '{1'b1, 4'b0100, 1'b0, 16'd1};
        vecs[10] = '{1'b1, 4'b0100, 1'b0, 16'd1};
        vecs[11] = '{1'b1, 4'b0100, 1'b0, 16'd1};
        vecs[12] = '{1'b0, 4'b1000, 1'b0, 16'd1};
        vecs[13] = '{1'b0, 4'b0001, 1'b1, 16'd2};

        m_reset();
        rst           = 1'b1;
        bus.en        = 1'b1;
        bus.step_mode = 1'b0;
        bus.step_req  = 1'b0;
        bus.stall     = 1'b0;
        bus.dwell_cfg = 16'h0000;
        #2 rst = 1'b0;
        tick();
        chk("reset_phase_en", 32'(bus.phase_en),    32'd0);
        chk("reset_idx",      32'(bus.phase_idx),   32'd0);
        chk("reset_busy",     32'(bus.busy),        32'd0);
        chk("reset_done",     32'(bus.cycle_done),  32'd0);
        chk("reset_count",    32'(bus.cycle_count), 32'd0);
        rst = 1'b1;

        // Legacy rotation and a 5-cycle stall in phase 2
        for (int i = 0; i < 14; i++) begin
            bus.stall = vecs[i].st;
            tick();
            chk($sformatf("vec%0d_phase_en", i), 32'(bus.phase_en),    32'(vecs[i].pe));
            chk($sformatf("vec%0d_done", i),     32'(bus.cycle_done),  32'(vecs[i].done));
            chk($sformatf("vec%0d_count", i),    32'(bus.cycle_count), 32'(vecs[i].cnt));
            chk($sformatf("vec%0d_busy", i),     32'(bus.busy),        32'd1);
        end
        bus.stall = 1'b0;

        // 21 edges after release: five completed legacy cycles
        do_reset(16'h0000, 1'b1, 1'b0);
        dones = 0;
        repeat (21) begin
            tick();
            if (bus.cycle_done) dones++;
        end
        chk("legacy_count", 32'(bus.cycle_count), 32'd5);
        chk("legacy_dones", 32'(dones), 32'd5);
        chk("legacy_phase", 32'(bus.phase_en), 32'b0001);

        // Programmed dwell {3,0,1,2}: phase lengths 3,2,1,4, period 10
        cfg = 16'h3012;
        do_reset(cfg, 1'b1, 1'b0);
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 4; i++) begin
                for (int k = 0; k <= int'(cfg[i*4 +: 4]); k++) begin
                    tick();
                    chk("dwell_phase_en", 32'(bus.phase_en), 32'd1 << i);
                    chk("dwell_done", 32'(bus.cycle_done), 32'(c == 1 && i == 0 && k == 0));
                end
            end
        end

        // Single step: step_req held high yields exactly one cycle
        do_reset(16'h0000, 1'b1, 1'b1);
        tick();
        chk("step_wait_idle", 32'(bus.busy), 32'd0);
        bus.step_req = 1'b1;
        repeat (20) tick();
        chk("step1_phase_en", 32'(bus.phase_en),    32'd0);
        chk("step1_busy",     32'(bus.busy),        32'd0);
        chk("step1_count",    32'(bus.cycle_count), 32'd1);
        bus.step_req = 1'b0;
        tick();
        bus.step_req = 1'b1;
        repeat (6) tick();
        chk("step2_count", 32'(bus.cycle_count), 32'd2);
        chk("step2_busy",  32'(bus.busy),        32'd0);
        bus.step_req = 1'b0;

        // Graceful stop: en dropped in phase 1
        do_reset(16'h0000, 1'b1, 1'b0);
        tick();
        tick();
        chk("stop_in_ph1", 32'(bus.phase_en), 32'b0010);
        bus.en = 1'b0;
        tick();
        chk("stop_ph2", 32'(bus.phase_en), 32'b0100);
        tick();
        chk("stop_ph3", 32'(bus.phase_en), 32'b1000);
        tick();
        chk("stop_idle",  32'(bus.phase_en),    32'd0);
        chk("stop_done",  32'(bus.cycle_done),  32'd1);
        chk("stop_count", 32'(bus.cycle_count), 32'd1);
        tick();
        chk("stop_done_clear", 32'(bus.cycle_done), 32'd0);

        // Asynchronous reset between edges while stalled in phase 2
        do_reset(16'h0000, 1'b1, 1'b0);
        repeat (7) tick();
        chk("areset_pre_phase", 32'(bus.phase_en),    32'b0100);
        chk("areset_pre_count", 32'(bus.cycle_count), 32'd1);
        bus.stall = 1'b1;
        repeat (2) tick();
        #2 rst = 1'b0;
        #1;
        chk("areset_phase_en", 32'(bus.phase_en),    32'd0);
        chk("areset_busy",     32'(bus.busy),        32'd0);
        chk("areset_count",    32'(bus.cycle_count), 32'd0);
        m_reset();
        bus.stall = 1'b0;
        rst = 1'b1;
        tick();
        chk("areset_restart", 32'(bus.phase_en), 32'b0001);

        // Randomized traffic against the slot-queue model
        for (int seg = 0; seg < 4; seg++) begin
            do_reset(16'($urandom), 1'b1, 1'($urandom % 2));
            for (int n = 0; n < 250; n++) begin
                bus.en       = ($urandom % 8) != 0;
                bus.stall    = ($urandom % 4) == 0;
                bus.step_req = 1'($urandom % 2);
                if ($urandom % 16 == 0) bus.step_mode = ~bus.step_mode;
                tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
- Parametrised successor to the fixed four-phase control FSM (fetch/decode/exec/writeback enables).
- Generates a one-hot phase enable across NUM_PHASES phases. Each phase has a programmable dwell time.
- Adds pipeline stall, graceful stop, single-step mode and a retired-cycle counter.
- Sits between the core clock/reset and the datapath stage enables.

Parameters:
- NUM_PHASES, 4, number of phases per instruction cycle (2..16).
- DWELL_W, 4, width of each per-phase dwell field.
- CNT_W, 16, width of the retired-instruction-cycle counter.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- en  in  1  run request; level-sensitive.
- step_mode  in  1  1 = execute one instruction cycle per step_req edge.
- step_req  in  1  step request; rising edge detected internally.
- stall  in  1  freeze the current phase and dwell count.
- dwell_cfg  in  NUM_PHASES*DWELL_W  per-phase dwell; field i = bits [i*DWELL_W +: DWELL_W].
- phase_en  out  NUM_PHASES  one-hot active phase; all-zero when idle.
- phase_idx  out  $clog2(NUM_PHASES)  index of the active phase.
- busy  out  1  state != IDLE.
- cycle_done  out  1  one-cycle pulse after the last phase completes.
- cycle_count  out  CNT_W  completed instruction cycles; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; phase_en=0; phase_idx=0; busy=0; cycle_done=0; cycle_count=0.
  - Dwell counter=0; step edge register=0.
  - Takes effect immediately, including mid-cycle or mid-stall.
- All outputs are registered.
- States: IDLE, RUN.
- IDLE -> RUN: at an edge where en=1 and either step_mode=0 or a step_req rising edge is detected (step_req=1 now, 0 on the previous edge).
  - After that edge: phase_en=one-hot(0); dwell counter loaded from dwell_cfg field 0.
- RUN, stall=1: everything holds — phase_en, phase_idx, dwell counter, cycle_count.
  - stall wins over any simultaneous advance.
- RUN, stall=0, dwell counter != 0: decrement the dwell counter.
- RUN, stall=0, dwell counter == 0, not last phase: advance to phase+1 and load its dwell field.
  - Dwell fields are sampled only at phase entry; changes mid-phase have no effect.
- RUN, stall=0, dwell counter == 0, last phase (NUM_PHASES-1):
  - Pulse cycle_done for one cycle; increment cycle_count (2^CNT_W-1 wraps to 0).
  - If en=1 and step_mode=0: go to phase 0 with no gap cycle (back-to-back).
  - Else: go to IDLE (phase_en=0), coincident with the cycle_done pulse.
- Phase duration: dwell d keeps the phase active for d+1 cycles. Instruction cycle length = sum of (d_i + 1).
- en dropped mid-cycle: the current instruction cycle completes (graceful stop), then IDLE. en is re-checked only at cycle boundaries.
- step_mode:
  - step_req edges while RUN are ignored and not queued.
  - step_req held high produces exactly one cycle.
  - step_mode changes take effect at the next cycle boundary.
- busy=1 exactly when phase_en != 0.

Decomposition:
- Shared package luna_ctrl_pkg:
  - State enum (IDLE, RUN).
  - Legacy phase index constants: PH_FETCH=0, PH_DECODE=1, PH_EXEC=2, PH_WRBK=3.
  - Helper function for the dwell field slice.
- One sub-module: phase_dwell_counter (load/decrement/hold, zero flag, width DWELL_W).
- Step edge detection and phase rotation stay in the top.

Test Plan:
- Legacy mode: NUM_PHASES=4, dwell_cfg=0, en=1, step_mode=0 from reset release.
  -> phase_en cycles 0001,0010,0100,1000,0001… one cycle each.
  -> cycle_done every 4th cycle; cycle_count=5 after 20 cycles of RUN.
- Dwell: dwell_cfg fields {3,0,1,2} for phases 3..0 (phase0=2, phase1=1, phase2=0, phase3=3).
  -> phase0 active 3 cycles, phase1 2, phase2 1, phase3 4; cycle_done period 10.
- Stall: assert stall for 5 cycles during phase 2 with legacy dwell.
  -> phase_en holds 0100 for 6 cycles, then 1000; cycle_done delayed by exactly 5 cycles.
- Step mode: step_mode=1, en=1, step_req held high 20 cycles then low.
  -> exactly one instruction cycle (4 phases), then IDLE, busy=0, cycle_count=1.
  -> A second 0->1 edge on step_req gives cycle_count=2.
- Graceful stop: drop en during phase 1.
  -> phases 2,3 still complete; cycle_done pulses; phase_en=0 the next cycle.
- Async reset during phase 2 with stall=1: rst=0 between clock edges.
  -> phase_en=0, cycle_count=0, busy=0 immediately, before the next clk edge.
  -> After reset release with en=1, restart at phase 0.
